// File: rtl/absmax_accum_pkg.sv
// Shared types and helpers for absmax_accum.
// Optional feature: ABSMAX_ACCUM_SAT_EN selects saturating lane sums.
package absmax_accum_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    localparam logic [1:0] SAT_NONE = 2'd0;
    localparam logic [1:0] SAT_POS  = 2'd1;
    localparam logic [1:0] SAT_NEG  = 2'd2;

    function automatic int cnt_width(input int window);
        return $clog2(window + 1);
    endfunction

    // Signed overflow of a+b happens only when both operands share a sign
    // and the result sign differs; the operand sign gives the clamp direction.
    function automatic logic [1:0] sat_add_kind(input logic a_msb,
                                                input logic b_msb,
                                                input logic r_msb);
        if ((a_msb == b_msb) && (r_msb != a_msb)) begin
            return a_msb ? SAT_NEG : SAT_POS;
        end
        return SAT_NONE;
    endfunction

endpackage

// File: rtl/absmax_lane.sv
// One lane of absmax_accum: |x| running max and running signed sum.
// Saturation (ABSMAX_ACCUM_SAT_EN) is sticky until the accumulators clear.
module absmax_lane
    import absmax_accum_pkg::*;
#(
    parameter int N     = 23,
    parameter int SUM_W = N + 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acc_en_i,
    input  logic             acc_clr_i,
    input  logic             use_acc_i,
    input  logic [N-1:0]     x_i,
    output logic [N-1:0]     res_max_o,
    output logic [SUM_W-1:0] res_sum_o
);

    logic [N-1:0]     acc_max_q, acc_max_d;
    logic [SUM_W-1:0] acc_sum_q, acc_sum_d;
    logic [N:0]       x_ext;
    logic [N:0]       x_abs;
    logic [SUM_W-1:0] x_sext;
    logic [SUM_W-1:0] sum_raw;

    // N+1 bits so that the most negative sample has a representable magnitude.
    assign x_ext   = {x_i[N-1], x_i};
    assign x_abs   = x_ext[N] ? -x_ext : x_ext;
    assign x_sext  = SUM_W'($signed(x_i));
    assign sum_raw = acc_sum_q + x_sext;

    always_comb begin
        acc_max_d = acc_max_q;
        if ({1'b0, acc_max_q} < x_abs) begin
            acc_max_d = x_abs[N-1:0];
        end
    end

`ifdef ABSMAX_ACCUM_SAT_EN
    logic       sat_q, sat_d;
    logic [1:0] sat_kind;

    assign sat_kind = sat_add_kind(acc_sum_q[SUM_W-1], x_sext[SUM_W-1], sum_raw[SUM_W-1]);

    always_comb begin
        acc_sum_d = sum_raw;
        sat_d     = sat_q;
        if (sat_q) begin
            acc_sum_d = acc_sum_q;
        end else if (sat_kind == SAT_POS) begin
            acc_sum_d = {1'b0, {(SUM_W-1){1'b1}}};
            sat_d     = 1'b1;
        end else if (sat_kind == SAT_NEG) begin
            acc_sum_d = {1'b1, {(SUM_W-1){1'b0}}};
            sat_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (acc_clr_i) begin
            sat_q <= 1'b0;
        end else if (acc_en_i) begin
            sat_q <= sat_d;
        end
    end
`else
    assign acc_sum_d = sum_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_max_q <= '0;
            acc_sum_q <= '0;
        end else if (acc_clr_i) begin
            acc_max_q <= '0;
            acc_sum_q <= '0;
        end else if (acc_en_i) begin
            acc_max_q <= acc_max_d;
            acc_sum_q <= acc_sum_d;
        end
    end

    // A direct close publishes the accumulators updated with the closing beat;
    // a release from HOLD publishes the already-updated accumulators.
    assign res_max_o = use_acc_i ? acc_max_q : acc_max_d;
    assign res_sum_o = use_acc_i ? acc_sum_q : acc_sum_d;

endmodule

// File: rtl/absmax_accum.sv
// Per-window, per-lane absolute-max and sum accumulator with valid/ready I/O.
// Optional feature: ABSMAX_ACCUM_SAT_EN (saturating sums in absmax_lane).
module absmax_accum
    import absmax_accum_pkg::*;
#(
    parameter int N      = 23,
    parameter int CH     = 4,
    parameter int WINDOW = 16,
    parameter int SUM_W  = N + 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CH*N-1:0]              in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CH*N-1:0]              out_max,
    output logic [CH*SUM_W-1:0]          out_sum,
    output logic [$clog2(WINDOW+1)-1:0]  out_count,
    output logic                         dbg_state_o
);

    localparam int CW = cnt_width(WINDOW);

    // Handshakes: a beat transfers when in_valid && in_ready, a result
    // transfers when out_valid && out_ready, both sampled at the rising edge.
    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [CH*N-1:0]       out_max_q;
    logic [CH*SUM_W-1:0]   out_sum_q;
    logic [CW-1:0]         out_count_q;
    logic [CH*N-1:0]       res_max;
    logic [CH*SUM_W-1:0]   res_sum;
    logic                  in_hs;
    logic                  close;
    logic                  out_free;
    logic                  load_direct;
    logic                  load_hold;
    logic                  load;
    logic                  in_hold;

    assign in_hold     = (state_q == ST_HOLD);
    assign in_hs       = in_valid && !in_hold;
    assign close       = in_hs && (in_last || (cnt_q == CW'(WINDOW - 1)));
    assign out_free    = !out_valid_q || out_ready;
    assign load_direct = close && out_free;
    assign load_hold   = in_hold && out_ready;
    assign load        = load_direct || load_hold;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_ACCUM: begin
                if (load_direct) begin
                    cnt_d = '0;
                end else if (close) begin
                    state_d = ST_HOLD;
                    cnt_d   = cnt_q + CW'(1);
                end else if (in_hs) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
        if (load) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_max_q   <= '0;
            out_sum_q   <= '0;
            out_count_q <= '0;
        end else if (load) begin
            out_max_q   <= res_max;
            out_sum_q   <= res_sum;
            out_count_q <= in_hold ? cnt_q : (cnt_q + CW'(1));
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_lane
        absmax_lane #(
            .N     (N),
            .SUM_W (SUM_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .acc_en_i  (in_hs && !load_direct),
            .acc_clr_i (load),
            .use_acc_i (in_hold),
            .x_i       (in_data[k*N +: N]),
            .res_max_o (res_max[k*N +: N]),
            .res_sum_o (res_sum[k*SUM_W +: SUM_W])
        );
    end

    assign in_ready    = !in_hold;
    assign out_valid   = out_valid_q;
    assign out_max     = out_max_q;
    assign out_sum     = out_sum_q;
    assign out_count   = out_count_q;
    assign dbg_state_o = state_q;

endmodule
